test_harness: RTL and testbench

- Self-checking top-level simulation harness; the only block instantiated by the simulation driver.
- After reset it runs a built-in memory self-test:
  - writes an LFSR pseudo-random pattern into an internal scratch RAM;
  - reads it back and compares.
- Raises a sticky success flag when all passes complete without mismatch.
- On mismatch it hangs with success low, so the driver's cycle timeout reports the failure.

---
 rtl/test_harness_pkg.sv | 34 +++
 rtl/test_harness_if.sv | 20 ++
 rtl/test_harness_ram.sv | 32 +++
 rtl/test_harness.sv | 138 +++++++++++++
 tb/tb_test_harness.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/test_harness_pkg.sv
// -----------------------------------------------------------------------------
// test_harness_pkg
// Shared types and helpers for the memory self-test harness.
//   state_e        : self-test FSM states
//   LFSR_TAPS      : Galois feedback taps of the 32-bit pattern generator
//   lfsr_next()    : one right-shift step of the Galois LFSR
//   seed_sanitise(): maps an all-zero seed (LFSR lock-up state) to 1
// -----------------------------------------------------------------------------
package test_harness_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_e;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   // Galois form: shift right, fold the taps in when the bit shifted out is 1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] fb;
      fb = s[0] ? LFSR_TAPS : 32'h0000_0000;
      return (s >> 1) ^ fb;
   endfunction

   // An all-zero state would make the LFSR stick at zero forever.
   function automatic logic [31:0] seed_sanitise(input logic [31:0] seed);
      return (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
   endfunction

endpackage

// File: rtl/test_harness_if.sv
// -----------------------------------------------------------------------------
// test_harness_if
// Scratch-RAM access bundle between the self-test controller and the RAM.
//   we/waddr/wdata : single write port
//   raddr/rdata    : synchronous read port, rdata valid one cycle after raddr
// Modports: master (controller side), slave (RAM side).
// -----------------------------------------------------------------------------
interface test_harness_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;

   modport master (output we, output waddr, output wdata, output raddr, input rdata);
   modport slave  (input we, input waddr, input wdata, input raddr, output rdata);
endinterface

// File: rtl/test_harness_ram.sv
// -----------------------------------------------------------------------------
// test_harness_ram
// DEPTH x DATA_W scratch RAM, DEPTH = 2**ADDR_W.
//   clock : rising-edge clock
//   bus   : test_harness_if slave modport (one write port, one synchronous
//           read port with one cycle of read latency)
// Contents are deliberately not reset; the self-test writes every word before
// reading it back.
// -----------------------------------------------------------------------------
module test_harness_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input logic           clock,
   test_harness_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_q;

   // Storage write and registered read.
   always_ff @(posedge clock) begin
      if (bus.we) begin
         mem_q[bus.waddr] <= bus.wdata;
      end
      rdata_q <= mem_q[bus.raddr];
   end

   assign bus.rdata = rdata_q;

endmodule

// File: rtl/test_harness.sv
// -----------------------------------------------------------------------------
// test_harness
// Top-level self-checking harness. After reset it fills a scratch RAM with an
// LFSR pattern, reads it back and compares against a second LFSR, repeating
// for PASSES passes. io_success rises (sticky) when every pass matched; on a
// mismatch the FSM parks in ERROR with io_success low.
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   io_success : registered pass flag, sticky until reset
// Optional feature macro: TEST_HARNESS_FAULT_INJECT_EN -- when defined, the
// pass-0 write to ERR_ADDR has bit 0 flipped so the self-test must fail.
// -----------------------------------------------------------------------------
module test_harness
   import test_harness_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter int          DATA_W   = 32,
   parameter logic [31:0] SEED     = 32'h0000_0001,
   parameter int          PASSES   = 2,
   parameter int          ERR_ADDR = 5
) (
   input  logic clock,
   input  logic reset,
   output logic io_success
);
   localparam logic [31:0]       SEED_C    = seed_sanitise(SEED);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [7:0]        LAST_PASS = 8'(PASSES - 1);

   test_harness_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

   test_harness_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clock (clock),
      .bus   (ram_bus.slave)
   );

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        pass_q;
   logic [31:0]       gen_q;
   logic [31:0]       chk_q;
   logic              cmp_valid_q;
   logic              success_q;

   logic [DATA_W-1:0] wdata_s;
   logic              mismatch_s;

   // Write data: generator word, optionally with one bit corrupted.
   always_comb begin
      wdata_s = gen_q[DATA_W-1:0];
`ifdef TEST_HARNESS_FAULT_INJECT_EN
      if ((pass_q == 8'd0) && (addr_q == ADDR_W'(ERR_ADDR))) begin
         wdata_s[0] = ~gen_q[0];
      end else begin
         wdata_s[0] = gen_q[0];
      end
`endif
   end

   // The read and write ports share one address counter; only the state
   // decides which of them is actually in use.
   assign ram_bus.we    = (state_q == ST_WRITE);
   assign ram_bus.waddr = addr_q;
   assign ram_bus.wdata = wdata_s;
   assign ram_bus.raddr = addr_q;

   // Comparator: data returned for the read issued on the previous edge.
   assign mismatch_s = cmp_valid_q && (ram_bus.rdata != chk_q[DATA_W-1:0]);

   // Self-test FSM with LFSRs, compare pipeline and registered success flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_INIT;
         addr_q      <= '0;
         pass_q      <= 8'd0;
         gen_q       <= SEED_C;
         chk_q       <= SEED_C;
         cmp_valid_q <= 1'b0;
         success_q   <= 1'b0;
      end else begin
         cmp_valid_q <= (state_q == ST_READ) && !mismatch_s;
         if (cmp_valid_q) begin
            chk_q <= lfsr_next(chk_q);
         end
         if (mismatch_s) begin
            // A mismatch wins over every other transition.
            state_q   <= ST_ERROR;
            success_q <= 1'b0;
         end else begin
            case (state_q)
               ST_INIT: begin
                  state_q <= ST_WRITE;
               end
               ST_WRITE: begin
                  gen_q  <= lfsr_next(gen_q);
                  addr_q <= addr_q + 1'b1;
                  if (addr_q == LAST_ADDR) begin
                     state_q <= ST_READ;
                  end
               end
               ST_READ: begin
                  addr_q <= addr_q + 1'b1;
                  if (addr_q == LAST_ADDR) begin
                     state_q <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  if (pass_q == LAST_PASS) begin
                     state_q   <= ST_DONE;
                     success_q <= 1'b1;
                  end else begin
                     pass_q  <= pass_q + 8'd1;
                     addr_q  <= '0;
                     // gen carries on, so the next pass sees a fresh pattern;
                     // chk restarts from the same point to track it.
                     chk_q   <= gen_q;
                     state_q <= ST_WRITE;
                  end
               end
               ST_DONE: begin
                  success_q <= 1'b1;
               end
               ST_ERROR: begin
                  success_q <= 1'b0;
               end
               default: begin
                  state_q   <= ST_ERROR;
                  success_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io_success = success_q;

endmodule

// File: tb/tb_test_harness.sv
// -----------------------------------------------------------------------------
// tb_test_harness
// Drives three harness instances (default, ADDR_W=2/PASSES=1, SEED=0 small)
// with scheduled and random resets. Reference: success must appear exactly
// 1 + PASSES*(2*DEPTH+1) reset-free edges after release, and the RAM must
// then hold the final pass of the seed-1 LFSR sequence.
// -----------------------------------------------------------------------------
module tb_test_harness;
   import test_harness_pkg::*;

   localparam int T_DEF   = 1 + 2 * (2 * 256 + 1);
   localparam int T_SMALL = 1 + 1 * (2 * 4 + 1);
   localparam int T_S0    = 1 + 3 * (2 * 16 + 1);

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_def   = 1'b1;
   logic rst_small = 1'b1;
   logic rst_s0    = 1'b1;
   logic succ_def, succ_small, succ_s0;

   int err_cnt = 0;
   int chk_cnt = 0;
   bit stop    = 1'b0;

   int k_def   = 0;
   int k_small = 0;
   int k_s0    = 0;

   logic [31:0] exp_def   [0:255];
   logic [31:0] exp_small [0:3];
   logic [31:0] exp_s0    [0:15];

   test_harness dut_def (.clock(clock), .reset(rst_def), .io_success(succ_def));
   test_harness #(.ADDR_W(2), .PASSES(1), .ERR_ADDR(1)) dut_small (
      .clock(clock), .reset(rst_small), .io_success(succ_small));
   test_harness #(.ADDR_W(4), .PASSES(3), .SEED(32'h0000_0000), .ERR_ADDR(3)) dut_s0 (
      .clock(clock), .reset(rst_s0), .io_success(succ_s0));

   // Reset-free edge count since the last reset edge, per instance.
   always @(posedge clock) begin
      k_def   <= rst_def   ? 0 : k_def + 1;
      k_small <= rst_small ? 0 : k_small + 1;
      k_s0    <= rst_s0    ? 0 : k_s0 + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // n steps of the 32-bit Galois LFSR, from the shift/tap rule directly.
   function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < n; i++) begin
         v = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_succ(input int k, input int t);
`ifdef TEST_HARNESS_FAULT_INJECT_EN
      return 32'h0;
`else
      return (k >= t) ? 32'h1 : 32'h0;
`endif
   endfunction

   task automatic check_all();
      check_eq("succ_def", 32'(succ_def), exp_succ(k_def, T_DEF));
      check_eq("succ_small", 32'(succ_small), exp_succ(k_small, T_SMALL));
      check_eq("succ_s0", 32'(succ_s0), exp_succ(k_s0, T_S0));
`ifdef TEST_HARNESS_FAULT_INJECT_EN
      if (k_def == 263) check_eq("pre_err_state", 32'(dut_def.state_q == ST_ERROR), 32'h0);
      if (k_def >= 264) check_eq("err_state", 32'(dut_def.state_q), 32'(ST_ERROR));
`else
      if (k_small >= T_SMALL) begin
         check_eq("small_w0", dut_small.u_ram.mem_q[0], 32'h0000_0001);
         check_eq("small_w1", dut_small.u_ram.mem_q[1], 32'h8020_0003);
         for (int i = 2; i < 4; i++)
            check_eq($sformatf("small_w%0d", i), dut_small.u_ram.mem_q[i], exp_small[i]);
      end
      if (k_s0 >= T_S0) begin
         for (int i = 0; i < 16; i++)
            check_eq($sformatf("s0_w%0d", i), dut_s0.u_ram.mem_q[i], exp_s0[i]);
      end
`endif
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge clock);
         check_all();
      end
   endtask

   // Random reset pulses for the small instance.
   initial begin
      repeat (3) @(negedge clock);
      rst_small = 1'b0;
      while (!stop) begin
         repeat ($urandom_range(4, 60)) @(negedge clock);
         rst_small = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clock);
         rst_small = 1'b0;
      end
   end

   // Random reset pulses for the SEED=0 instance.
   initial begin
      repeat (4) @(negedge clock);
      rst_s0 = 1'b0;
      while (!stop) begin
         repeat ($urandom_range(50, 400)) @(negedge clock);
         rst_s0 = 1'b1;
         repeat ($urandom_range(1, 4)) @(negedge clock);
         rst_s0 = 1'b0;
      end
   end

   // Scheduled run of the default instance and the final summary.
   initial begin
      for (int a = 0; a < 256; a++) exp_def[a] = lfsr_adv(32'h1, 256 + a);
      for (int a = 0; a < 4; a++)   exp_small[a] = lfsr_adv(32'h1, a);
      for (int a = 0; a < 16; a++)  exp_s0[a] = lfsr_adv(32'h1, 2 * 16 + a);

      run_cycles(5);
      rst_def = 1'b0;
      run_cycles(1130);
`ifndef TEST_HARNESS_FAULT_INJECT_EN
      check_eq("def_w0", dut_def.u_ram.mem_q[0], exp_def[0]);
      check_eq("def_w5", dut_def.u_ram.mem_q[5], exp_def[5]);
      check_eq("def_w255", dut_def.u_ram.mem_q[255], exp_def[255]);
`endif
      // Fresh run interrupted by a 3-cycle reset at cycle 300.
      rst_def = 1'b1;
      run_cycles(2);
      rst_def = 1'b0;
      run_cycles(300);
      rst_def = 1'b1;
      run_cycles(3);
      rst_def = 1'b0;
      run_cycles(1130);
      // Long reset hold.
      rst_def = 1'b1;
      repeat (2000) begin
         @(negedge clock);
         check_all();
         check_eq("hold_state", 32'(dut_def.state_q), 32'(ST_INIT));
      end
      stop = 1'b1;
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
